// File: rtl/puf_ctrl_pkg.sv
// Shared types and constants for the PUF challenge driver: FSM state encoding,
// default LFSR feedback mask and seed, and the evaluation bit-period helper.
package puf_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StArm,
    StLaunch,
    StSettle,
    StSample,
    StNext,
    StOutput
  } puf_state_e;

  localparam logic [31:0] DefLfsrTaps = 32'h8020_0003;
  localparam logic [31:0] DefSeed     = 32'h0000_0001;

  // Cycles spent on one response bit; evals is 3 with majority voting, else 1.
  function automatic int unsigned bit_period(input int unsigned clr_cycles,
                                             input int unsigned settle_cycles,
                                             input int unsigned evals);
    return evals * (clr_cycles + 3 + settle_cycles);
  endfunction

endpackage

// File: rtl/lfsr_challenge_gen.sv
// Galois LFSR producing PUF challenges; a zero load value is replaced by 1 so
// the register can never lock up in the all-zero state.
module lfsr_challenge_gen
  import puf_ctrl_pkg::*;
#(
  parameter int unsigned       Width     = 32,
  parameter logic [Width-1:0] Taps      = Width'(DefLfsrTaps),
  parameter logic [Width-1:0] ResetSeed = Width'(DefSeed)
) (
  input  logic             clk_i,
  input  logic             clr_ni,
  input  logic             load_i,
  input  logic [Width-1:0] seed_i,
  input  logic             step_i,
  output logic [Width-1:0] state_o
);

  logic [Width-1:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (load_i) begin
      state_d = (seed_i == '0) ? Width'(1) : seed_i;
    end else if (step_i) begin
      state_d = (state_q >> 1) ^ (state_q[0] ? Taps : '0);
    end
  end

  always_ff @(posedge clk_i or negedge clr_ni) begin
    if (!clr_ni) begin
      state_q <= ResetSeed;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/puf_challenge_driver.sv
// Sequences clear/launch/settle/sample for each PUF challenge and packs a batch
// of responses for a valid/ready consumer. MAJORITY_VOTE_EN: 3 evals per bit.
module puf_challenge_driver
  import puf_ctrl_pkg::*;
#(
  parameter int unsigned      CH_W          = 32,
  parameter int unsigned      N_RESP        = 32,
  parameter int unsigned      SETTLE_CYCLES = 8,
  parameter int unsigned      CLR_CYCLES    = 2,
  parameter logic [CH_W-1:0] LFSR_TAPS     = CH_W'(DefLfsrTaps),
  parameter logic [CH_W-1:0] DEF_SEED      = CH_W'(DefSeed)
) (
  input  logic              clk_i,
  input  logic              clr_ni,
  input  logic              start_i,
  input  logic              seed_load_i,
  input  logic [CH_W-1:0]   seed_i,
  output logic              puf_clk_o,
  output logic              puf_clr_o,
  output logic [CH_W-1:0]   puf_chal_o,
  input  logic              puf_resp_i,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [N_RESP-1:0] resp_data_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int unsigned CntW   = (N_RESP > 1) ? $clog2(N_RESP) : 1;
  localparam int unsigned CycMax = (CLR_CYCLES > SETTLE_CYCLES) ? CLR_CYCLES : SETTLE_CYCLES;
  localparam int unsigned CycW   = $clog2(CycMax + 1);

  localparam logic [CntW-1:0] LastBit     = CntW'(N_RESP - 1);
  localparam logic [CycW-1:0] ClrLoad     = CycW'(CLR_CYCLES - 1);
  // NEXT already counts as the first clear cycle.
  localparam logic [CycW-1:0] ClrNextLoad = CycW'((CLR_CYCLES > 1) ? CLR_CYCLES - 2 : 0);
  localparam logic [CycW-1:0] SettleLoad  = CycW'(SETTLE_CYCLES - 1);

  puf_state_e        state_q, state_d;
  logic [CycW-1:0]   cyc_q, cyc_d;
  logic [CntW-1:0]   bit_q, bit_d;
  logic [N_RESP-1:0] data_q, data_d;
  logic              done_q, done_d;
  logic              puf_clk_q, puf_clk_d;
  logic              puf_clr_q, puf_clr_d;
  logic [1:0]        sync_q;
  logic              sample_bit;
  logic              bit_done;
  logic              lfsr_load, lfsr_step;
  logic [CH_W-1:0]   lfsr_state;

`ifdef MAJORITY_VOTE_EN
  logic [1:0] rep_q, rep_d;
  logic [1:0] votes_q, votes_d;
`endif

  assign sample_bit = sync_q[1];

  lfsr_challenge_gen #(
    .Width     (CH_W),
    .Taps      (LFSR_TAPS),
    .ResetSeed (DEF_SEED)
  ) u_lfsr (
    .clk_i   (clk_i),
    .clr_ni  (clr_ni),
    .load_i  (lfsr_load),
    .seed_i  (seed_i),
    .step_i  (lfsr_step),
    .state_o (lfsr_state)
  );

  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    bit_d     = bit_q;
    data_d    = data_q;
    done_d    = 1'b0;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;
    bit_done  = 1'b0;
`ifdef MAJORITY_VOTE_EN
    rep_d     = rep_q;
    votes_d   = votes_q;
`endif

    unique case (state_q)
      StIdle: begin
        lfsr_load = seed_load_i;
        if (start_i) begin
          state_d = StClear;
          cyc_d   = ClrLoad;
        end
      end
      StClear: begin
        if (cyc_q == '0) begin
          state_d = StArm;
        end else begin
          cyc_d = cyc_q - CycW'(1);
        end
      end
      StArm: begin
        state_d = StLaunch;
      end
      StLaunch: begin
        state_d = StSettle;
        cyc_d   = SettleLoad;
      end
      StSettle: begin
        if (cyc_q == '0) begin
          state_d = StSample;
        end else begin
          cyc_d = cyc_q - CycW'(1);
        end
      end
      StSample: begin
`ifdef MAJORITY_VOTE_EN
        if (rep_q != 2'd2) begin
          rep_d   = rep_q + 2'd1;
          votes_d = votes_q + {1'b0, sample_bit};
          state_d = StClear;
          cyc_d   = ClrLoad;
        end else begin
          // Majority of three: two earlier ones, or one earlier one plus this sample.
          data_d[bit_q] = votes_q[1] | (votes_q[0] & sample_bit);
          rep_d         = '0;
          votes_d       = '0;
          bit_done      = 1'b1;
        end
`else
        data_d[bit_q] = sample_bit;
        bit_done      = 1'b1;
`endif
      end
      StNext: begin
        state_d = (CLR_CYCLES > 1) ? StClear : StArm;
        cyc_d   = ClrNextLoad;
        bit_d   = bit_q + CntW'(1);
      end
      StOutput: begin
        if (resp_ready_i) begin
          state_d   = StIdle;
          done_d    = 1'b1;
          bit_d     = '0;
          lfsr_step = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Step on the SAMPLE->NEXT edge so the new challenge is in place for all clear cycles.
    if (bit_done) begin
      if (bit_q == LastBit) begin
        state_d = StOutput;
      end else begin
        state_d   = StNext;
        lfsr_step = 1'b1;
      end
    end

    puf_clk_d = (state_d == StLaunch) || (state_d == StSettle);
    puf_clr_d = !((state_d == StArm) || (state_d == StLaunch) || (state_d == StSettle));
  end

  always_ff @(posedge clk_i or negedge clr_ni) begin
    if (!clr_ni) begin
      state_q   <= StIdle;
      cyc_q     <= '0;
      bit_q     <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
      puf_clk_q <= 1'b0;
      puf_clr_q <= 1'b1;
      sync_q    <= '0;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      bit_q     <= bit_d;
      data_q    <= data_d;
      done_q    <= done_d;
      puf_clk_q <= puf_clk_d;
      puf_clr_q <= puf_clr_d;
      sync_q    <= {sync_q[0], puf_resp_i};
    end
  end

`ifdef MAJORITY_VOTE_EN
  always_ff @(posedge clk_i or negedge clr_ni) begin
    if (!clr_ni) begin
      rep_q   <= '0;
      votes_q <= '0;
    end else begin
      rep_q   <= rep_d;
      votes_q <= votes_d;
    end
  end
`endif

  assign puf_clk_o    = puf_clk_q;
  assign puf_clr_o    = puf_clr_q;
  assign puf_chal_o   = lfsr_state;
  assign resp_valid_o = (state_q == StOutput);
  assign resp_data_o  = data_q;
  assign busy_o       = (state_q != StIdle);
  assign done_o       = done_q;

endmodule

// File: tb/tb_puf_challenge_driver.sv
// Randomized self-checking bench for puf_challenge_driver with a behavioural
// PUF model, a challenge-sequence reference and an output-protocol monitor.
module tb_puf_challenge_driver;

  localparam int unsigned N      = 4;
  localparam int unsigned SETTLE = 8;
  localparam int unsigned CLRC   = 2;
`ifdef MAJORITY_VOTE_EN
  localparam int unsigned EVALS  = 3;
`else
  localparam int unsigned EVALS  = 1;
`endif
  localparam int unsigned PERIOD = EVALS * (CLRC + 3 + SETTLE);
  localparam logic [31:0] TAPS   = 32'h8020_0003;
  localparam logic [31:0] SEED0  = 32'h0000_0001;

  logic          clk = 1'b0;
  logic          clr_n = 1'b1;
  logic          start = 1'b0;
  logic          seed_load = 1'b0;
  logic [31:0]   seed = '0;
  logic          puf_clk, puf_clr;
  logic [31:0]   puf_chal;
  logic          puf_resp = 1'b0;
  logic          resp_valid;
  logic          resp_ready = 1'b0;
  logic [N-1:0]  resp_data;
  logic          busy, done;

  int n_checks = 0;
  int n_errors = 0;

  puf_challenge_driver #(
    .CH_W          (32),
    .N_RESP        (N),
    .SETTLE_CYCLES (SETTLE),
    .CLR_CYCLES    (CLRC)
  ) dut (
    .clk_i        (clk),
    .clr_ni       (clr_n),
    .start_i      (start),
    .seed_load_i  (seed_load),
    .seed_i       (seed),
    .puf_clk_o    (puf_clk),
    .puf_clr_o    (puf_clr),
    .puf_chal_o   (puf_chal),
    .puf_resp_i   (puf_resp),
    .resp_valid_o (resp_valid),
    .resp_ready_i (resp_ready),
    .resp_data_o  (resp_data),
    .busy_o       (busy),
    .done_o       (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] galois(input logic [31:0] s);
    return (s >> 1) ^ (((s & 32'h1) != 0) ? TAPS : 32'h0);
  endfunction

  // Behavioural PUF: decides its response on each launch edge and logs it.
  int          resp_mode = 0;
  int          eval_base = 0;
  bit          evals[$];
  logic [31:0] chals[$];

  always @(posedge puf_clk) begin
    case (resp_mode)
      0:       puf_resp = 1'b1;
      1:       puf_resp = puf_chal[0];
      2:       puf_resp = 1'($urandom);
      default: puf_resp = ((evals.size() - eval_base) % 3) != 1;
    endcase
    evals.push_back(puf_resp);
    chals.push_back(puf_chal);
  end

  // Output protocol monitor, sampled on the falling clock edge.
  int          viol = 0;
  int          rises_total = 0;
  logic        prev_clk = 1'b0, prev_clr = 1'b1;
  logic [31:0] prev_chal = '0, chal_arm = '0;
  int          low_run = 0, hi_run = 0, clr_hi_run = 0;

  always @(negedge clk) begin : mon
    int v;
    v = 0;
    if (!clr_n) begin
      prev_clk   <= 1'b0;
      prev_clr   <= 1'b1;
      prev_chal  <= puf_chal;
      low_run    <= 0;
      hi_run     <= 0;
      clr_hi_run <= 0;
    end else begin
      if (puf_clk && puf_clr) v = v + 1;
      if (puf_chal != prev_chal && !(puf_clr && prev_clr)) v = v + 1;
      if (puf_clk && !prev_clk) begin
        rises_total <= rises_total + 1;
        if (low_run != 1 || !busy) v = v + 1;
      end
      if (!puf_clk && prev_clk) begin
        if (hi_run != int'(SETTLE + 1)) v = v + 1;
        if (puf_chal != chal_arm) v = v + 1;
      end
      if (!puf_clr && prev_clr) begin
        chal_arm <= puf_chal;
        if (clr_hi_run < int'(CLRC + 1)) v = v + 1;
      end
      if (puf_clr && !prev_clr && low_run != int'(SETTLE + 2)) v = v + 1;
      low_run    <= puf_clr ? 0 : low_run + 1;
      hi_run     <= puf_clk ? hi_run + 1 : 0;
      clr_hi_run <= puf_clr ? clr_hi_run + 1 : 0;
      prev_clk   <= puf_clk;
      prev_clr   <= puf_clr;
      prev_chal  <= puf_chal;
      viol       <= viol + v;
    end
  end

  logic [31:0] ref_lfsr = SEED0;

  task automatic load_only(input logic [31:0] val);
    @(negedge clk);
    seed      = val;
    seed_load = 1'b1;
    @(negedge clk);
    seed_load = 1'b0;
    ref_lfsr  = (val == 0) ? 32'h1 : val;
    check("seed_load_chal", puf_chal, ref_lfsr);
  endtask

  task automatic run_batch(input int mode, input int ready_delay,
                           input bit do_load, input logic [31:0] load_val);
    int          n;
    int          base_e;
    int          base_r;
    logic [N-1:0] snap, exp_data;
    logic [31:0] s;
    int          ones;
    if (do_load) ref_lfsr = (load_val == 0) ? 32'h1 : load_val;
    @(negedge clk);
    resp_mode = mode;
    eval_base = evals.size();
    base_e    = evals.size();
    base_r    = rises_total;
    seed      = load_val;
    seed_load = do_load;
    start     = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      start     = 1'b0;
      seed_load = 1'b0;
      n++;
    end while (!resp_valid && n < int'(PERIOD * N + 50));
    check("latency", n, PERIOD * N + 1);
    snap = resp_data;
    check("launches", rises_total - base_r, N * EVALS);
    check("eval_count", evals.size() - base_e, N * EVALS);
    s = ref_lfsr;
    exp_data = '0;
    if (evals.size() - base_e == int'(N * EVALS)) begin
      for (int i = 0; i < int'(N); i++) begin
        ones = 0;
        for (int j = 0; j < int'(EVALS); j++) begin
          ones += int'(evals[base_e + i * EVALS + j]);
          check("chal_seq", chals[base_e + i * EVALS + j], s);
        end
        exp_data[i] = (2 * ones > int'(EVALS));
        s = galois(s);
      end
    end
    check("resp_data", resp_data, exp_data);
`ifdef MAJORITY_VOTE_EN
    if (mode == 3) check("majority_101", resp_data, {N{1'b1}});
`endif
    for (int d = 0; d < ready_delay; d++) begin
      if ($urandom_range(0, 1) == 1) begin
        start     = 1'b1;
        seed_load = 1'($urandom);
        seed      = $urandom;
      end
      @(negedge clk);
      start     = 1'b0;
      seed_load = 1'b0;
      check("hold_valid", resp_valid, 1'b1);
      check("hold_data", resp_data, snap);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check("done_pulse", done, 1'b1);
    check("valid_drop", resp_valid, 1'b0);
    check("busy_idle", busy, 1'b0);
    @(negedge clk);
    check("done_single", done, 1'b0);
    check("no_restart", busy, 1'b0);
    ref_lfsr = s;
    check("chal_continue", puf_chal, ref_lfsr);
  endtask

  initial begin
    int n;
    int base_r;
    #1 clr_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_puf_clk", puf_clk, 1'b0);
    check("rst_puf_clr", puf_clr, 1'b1);
    check("rst_valid", resp_valid, 1'b0);
    check("rst_data", resp_data, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_chal", puf_chal, SEED0);
    clr_n = 1'b1;
    @(negedge clk);

    run_batch(0, 0, 1'b0, 32'h0);
    load_only(32'h0);
    run_batch(1, 0, 1'b1, 32'h0);
    load_only(32'hA5A5_A5A5);
    run_batch(1, 20, 1'b0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      run_batch(2, $urandom_range(0, 5), 1'b1, $urandom);
    end
    run_batch(3, 2, 1'b0, 32'h0);

    // Abort a batch while bit 2 is settling.
    @(negedge clk);
    resp_mode = 1;
    base_r    = rises_total;
    start     = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      n++;
    end while (rises_total - base_r < int'(2 * EVALS + 1) && n < int'(PERIOD * N + 50));
    check("abort_reached", rises_total - base_r, 2 * EVALS + 1);
    repeat (3) @(negedge clk);
    #2 clr_n = 1'b0;
    #1;
    check("abort_puf_clk", puf_clk, 1'b0);
    check("abort_puf_clr", puf_clr, 1'b1);
    check("abort_valid", resp_valid, 1'b0);
    check("abort_data", resp_data, '0);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_chal", puf_chal, SEED0);
    @(negedge clk);
    @(negedge clk);
    clr_n    = 1'b1;
    ref_lfsr = SEED0;
    run_batch(1, 0, 1'b0, 32'h0);

    repeat (2) @(negedge clk);
    check("protocol", viol, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
